// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared constants and types for the instruction-fetch stage:
//            the NOP word, the fetch FSM state encoding, the default reset
//            PC and exception vector, and a word-alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_mux
// Purpose  : Priority select of the redirect target.
//            Priority: exc_req > jr_req > jump_req > branch_req.
// Ports    : exc_req/jr_req/jump_req/branch_req - redirect requests
//            jr_target/jump_target/branch_target - candidate targets
//            redirect - any request active
//            target   - selected target, word aligned
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_mux
  import ifetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        exc_req,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = exc_req | jr_req | jump_req | branch_req;
    if (exc_req)       target = word_align(EXC_VECTOR);
    else if (jr_req)   target = word_align(jr_target);
    else if (jump_req) target = word_align(jump_target);
    else               target = word_align(branch_target);
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : IF stage of the 5-stage MIPS pipeline. Owns the PC, the
//            instruction-memory request handshake, the stall hold buffer
//            and the redirect/flush logic feeding the IF/ID register.
// Ports    : clk, reset (async, active-low)
//            datahazard - stall; PC and IF/ID hold
//            exc_req / jr_req / jump_req / branch_req + targets - redirects
//            imem_req, imem_addr, imem_ready, imem_rdata - memory handshake
//            instructionout, PCplusout, flush - to IF/ID
//            fetch_count, bubble_count - only with IFETCH_PERF_EN
// Config   : `define IFETCH_PERF_EN adds the fetch/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        datahazard,
  input  logic        exc_req,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instructionout,
  output logic [31:0] PCplusout,
  output logic        flush
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_addr;   // address of the request outstanding in S_WAIT/S_DISCARD
  logic         hold_valid;
  logic [31:0]  hold_instr;

  logic         redirect;
  logic [31:0]  target;
  logic         take;       // redirect actually acted upon (ignored during a stall)
  logic         deliver;    // a valid instruction is presented from memory this cycle
  logic         hold_release;
  logic         pc_adv;
  logic [31:0]  pc_plus4;

  pc_next_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_mux (
    .exc_req       (exc_req),
    .jr_req        (jr_req),
    .jr_target     (jr_target),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .redirect      (redirect),
    .target        (target)
  );

  assign take      = redirect & ~datahazard;
  assign flush     = redirect;
  assign pc_plus4  = pc + 32'd4;
  assign PCplusout = pc_plus4;

  // Outputs are gated by reset so an abandoned request drops immediately.
  always_comb begin
    imem_req       = 1'b0;
    imem_addr      = pc;
    instructionout = NOP_WORD;
    deliver        = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          if (take) begin
            instructionout = NOP_WORD;
          end else if (hold_valid) begin
            instructionout = hold_instr;
          end else begin
            imem_req = 1'b1;
            if (imem_ready) begin
              instructionout = imem_rdata;
              deliver        = 1'b1;
            end
          end
        end
        S_WAIT: begin
          imem_req  = 1'b1;
          imem_addr = req_addr;
          // A redirect arriving with the data wins; the data is dropped.
          if (imem_ready && !take) begin
            instructionout = imem_rdata;
            deliver        = 1'b1;
          end
        end
        S_DISCARD: begin
          imem_req  = 1'b1;
          imem_addr = req_addr;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign hold_release = (state == S_FETCH) && hold_valid && !take && !datahazard;
  assign pc_adv       = (deliver && !datahazard) || hold_release;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      state      <= S_FETCH;
      hold_valid <= 1'b0;
      hold_instr <= NOP_WORD;
      req_addr   <= RESET_PC;
    end else begin
      if (take) begin
        pc         <= target;
        hold_valid <= 1'b0;
      end else if (pc_adv) begin
        pc         <= pc_plus4;
        hold_valid <= 1'b0;
      end else if (deliver) begin
        // Delivered under a stall: keep it until the stall clears.
        hold_instr <= imem_rdata;
        hold_valid <= 1'b1;
      end

      case (state)
        S_FETCH: begin
          if (!take && !hold_valid && !imem_ready) begin
            state    <= S_WAIT;
            req_addr <= pc;
          end
        end
        S_WAIT: begin
          if (imem_ready)  state <= S_FETCH;
          else if (take)   state <= S_DISCARD;
        end
        S_DISCARD: begin
          if (imem_ready) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic bubble;
  assign bubble = take || (state == S_DISCARD) || ((state == S_WAIT) && !imem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (pc_adv) fetch_count  <= fetch_count + 32'd1;
      if (bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Self-checking bench for ifetch_unit. A request-level reference
//            model (outstanding request, drop flag, held instruction) predicts
//            all outputs each cycle; directed scenarios plus a random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        datahazard = 1'b0;
  logic        exc_req = 1'b0, jr_req = 1'b0, jump_req = 1'b0, branch_req = 1'b0;
  logic [31:0] jr_target = '0, jump_target = '0, branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instructionout;
  logic [31:0] PCplusout;
  logic        flush;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  int checks = 0;
  int errors = 0;

  ifetch_unit #(
    .RESET_PC   (RST_PC),
    .EXC_VECTOR (EXC_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .datahazard     (datahazard),
    .exc_req        (exc_req),
    .jr_req         (jr_req),
    .jr_target      (jr_target),
    .jump_req       (jump_req),
    .jump_target    (jump_target),
    .branch_req     (branch_req),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instructionout (instructionout),
    .PCplusout      (PCplusout),
    .flush          (flush)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic        m_busy;        // a request is outstanding in memory
  logic [31:0] m_busy_addr;
  logic        m_drop;        // outstanding data must be thrown away
  logic        m_held;
  logic [31:0] m_held_word;
  int unsigned m_fetch, m_bubble;
  logic [97:0] e_vec;
  logic        use_override = 1'b0;
  logic [31:0] override_data = '0;

  wire [97:0] obs_vec = {imem_req, (imem_req ? imem_addr : 32'h0), instructionout, PCplusout, flush};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] sel_target();
    logic [31:0] t;
    if (exc_req)       t = EXC_PC;
    else if (jr_req)   t = jr_target;
    else if (jump_req) t = jump_target;
    else               t = branch_target;
    return {t[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_busy = 1'b0; m_busy_addr = '0; m_drop = 1'b0;
    m_held = 1'b0; m_held_word = '0; m_fetch = 0; m_bubble = 0;
  endtask

  task automatic model_eval();
    logic red, act, e_req;
    logic [31:0] e_addr, e_instr;
    red = exc_req | jr_req | jump_req | branch_req;
    act = red & ~datahazard;
    if (!m_busy) begin
      e_req   = !m_held && !act;
      e_addr  = m_pc;
      e_instr = act ? 32'h0 : (m_held ? m_held_word : (imem_ready ? imem_rdata : 32'h0));
    end else begin
      e_req   = 1'b1;
      e_addr  = m_busy_addr;
      e_instr = (!m_drop && !act && imem_ready) ? imem_rdata : 32'h0;
    end
    e_vec = {e_req, (e_req ? e_addr : 32'h0), e_instr, m_pc + 32'd4, red};
  endtask

  task automatic model_advance();
    logic act, got, release_h, was_busy;
    act       = (exc_req | jr_req | jump_req | branch_req) & ~datahazard;
    was_busy  = m_busy;
    got       = imem_ready && !act && ((!m_busy && !m_held) || (m_busy && !m_drop));
    release_h = !m_busy && m_held && !act && !datahazard;
    if (act || (m_busy && (m_drop || !imem_ready))) m_bubble++;
    if (act) begin m_pc = sel_target(); m_held = 1'b0; end
    if (was_busy) begin
      if (imem_ready) m_busy = 1'b0;
      else if (act)   m_drop = 1'b1;
    end else if (!m_held && !act && !imem_ready) begin
      m_busy = 1'b1; m_busy_addr = m_pc; m_drop = 1'b0;
    end
    if (got) begin
      if (!datahazard) begin m_pc = m_pc + 32'd4; m_fetch++; end
      else begin m_held = 1'b1; m_held_word = imem_rdata; end
    end else if (release_h) begin
      m_pc = m_pc + 32'd4; m_held = 1'b0; m_fetch++;
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic idle_inputs();
    datahazard = 1'b0; exc_req = 1'b0; jr_req = 1'b0; jump_req = 1'b0; branch_req = 1'b0;
    imem_ready = 1'b1; use_override = 1'b0;
  endtask

  // Inputs are set just after a falling edge; settle drives the memory data
  // and samples well before the rising edge.
  task automatic settle();
    imem_rdata = use_override ? override_data : mem_word(m_busy ? m_busy_addr : m_pc);
    #3;
    model_eval();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    #3;
    checks++;
    if ({imem_req, instructionout, PCplusout, flush} !== {1'b0, 32'h0, RST_PC + 32'd4, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got req=%b instr=%h pcp=%h flush=%b want 0/0/%h/0",
               imem_req, instructionout, PCplusout, flush, RST_PC + 32'd4);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    settle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_first_fetch got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      settle();
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL seq_model cyc%0d got %h want %h", i, obs_vec, e_vec);
      end
      checks++;
      if (imem_addr !== 32'(i * 4) || PCplusout !== 32'(i * 4 + 4) || flush !== 1'b0) begin
        errors++;
        $display("FAIL seq_addr cyc%0d got addr=%h pcp=%h flush=%b want %h/%h/0",
                 i, imem_addr, PCplusout, flush, 32'(i * 4), 32'(i * 4 + 4));
      end
      tick();
    end
  endtask

  task automatic test_wait();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      imem_ready = !(i >= 2 && i <= 4);
      settle();
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL wait_model cyc%0d got %h want %h", i, obs_vec, e_vec);
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (imem_addr !== 32'h8 || instructionout !== 32'h0) begin
          errors++;
          $display("FAIL wait_hold cyc%0d got addr=%h instr=%h want 8/0", i, imem_addr, instructionout);
        end
      end
      if (i == 5) begin
        checks++;
        if (instructionout !== mem_word(32'h8)) begin
          errors++; $display("FAIL wait_deliver got %h want %h", instructionout, mem_word(32'h8));
        end
      end
      if (i == 6) begin
        checks++;
        if (imem_addr !== 32'hC) begin
          errors++; $display("FAIL wait_next got %h want 0000000c", imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      datahazard = (i == 1 || i == 2);
      settle();
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL stall_model cyc%0d got %h want %h", i, obs_vec, e_vec);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (instructionout !== mem_word(32'h4) || imem_req !== 1'b0 || PCplusout !== 32'h8) begin
          errors++;
          $display("FAIL stall_hold cyc%0d got instr=%h req=%b pcp=%h want %h/0/8",
                   i, instructionout, imem_req, PCplusout, mem_word(32'h4));
        end
      end
      if (i == 4) begin
        checks++;
        if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin
          errors++; $display("FAIL stall_resume got req=%b addr=%h want 1/8", imem_req, imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      branch_target = 32'h100; jump_target = 32'h200;
      if (i == 1) begin branch_req = 1'b1; jump_req = 1'b1; end
      if (i == 3) begin branch_req = 1'b1; jump_req = 1'b1; exc_req = 1'b1; end
      settle();
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL prio_model cyc%0d got %h want %h", i, obs_vec, e_vec);
      end
      if (i == 2 || i == 4) begin
        checks++;
        if (imem_addr !== ((i == 2) ? 32'h200 : EXC_PC)) begin
          errors++; $display("FAIL prio_target cyc%0d got %h want %h", i, imem_addr,
                             (i == 2) ? 32'h200 : EXC_PC);
        end
      end
      tick();
    end
  endtask

  task automatic test_discard();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      imem_ready = (i >= 3);
      if (i == 1) begin jump_req = 1'b1; jump_target = 32'h41; end
      if (i == 3) begin use_override = 1'b1; override_data = 32'hDEAD; end
      settle();
      checks++;
      if (obs_vec !== e_vec || instructionout === 32'hDEAD) begin
        errors++; $display("FAIL discard_model cyc%0d got %h want %h", i, obs_vec, e_vec);
      end
      if (i == 4) begin
        checks++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
          errors++; $display("FAIL discard_next got req=%b addr=%h want 1/40", imem_req, imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      if (i == 0) begin jump_req = 1'b1; jump_target = 32'hFFFF_FFFC; end
      settle();
      checks++;
      if (obs_vec !== e_vec) begin
        errors++; $display("FAIL wrap_model cyc%0d got %h want %h", i, obs_vec, e_vec);
      end
      if (i == 1) begin
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC || PCplusout !== 32'h0) begin
          errors++; $display("FAIL wrap_pcplus got addr=%h pcp=%h want fffffffc/0", imem_addr, PCplusout);
        end
      end
      if (i == 2) begin
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
          errors++; $display("FAIL wrap_next got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle_inputs();
    settle();
    tick();
    idle_inputs();
    imem_ready = 1'b0;
    settle();
    tick();
    idle_inputs();
    imem_ready = 1'b0;
    settle();
    checks++;
    if (obs_vec !== e_vec) begin
      errors++; $display("FAIL rstmid_wait got %h want %h", obs_vec, e_vec);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instructionout !== 32'h0) begin
      errors++; $display("FAIL rstmid_drop got req=%b instr=%h want 0/0", imem_req, instructionout);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    idle_inputs();
    settle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || obs_vec !== e_vec) begin
      errors++; $display("FAIL rstmid_restart got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      datahazard    = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 2) != 0);
      exc_req       = ($urandom_range(0, 31) == 0);
      jr_req        = ($urandom_range(0, 15) == 0);
      jump_req      = ($urandom_range(0, 15) == 0);
      branch_req    = ($urandom_range(0, 15) == 0);
      jr_target     = $urandom;
      jump_target   = $urandom;
      branch_target = $urandom;
      if ($urandom_range(0, 1) == 1) begin use_override = 1'b1; override_data = $urandom; end
      settle();
      checks++;
      if (obs_vec !== e_vec) begin
        errors++;
        if (bad < 10) $display("FAIL rand_model cyc%0d got %h want %h", i, obs_vec, e_vec);
        bad++;
      end
      tick();
    end
`ifdef IFETCH_PERF_EN
    checks++;
    if (fetch_count !== 32'(m_fetch) || bubble_count !== 32'(m_bubble)) begin
      errors++;
      $display("FAIL perf_counts got fetch=%0d bubble=%0d want %0d/%0d",
               fetch_count, bubble_count, m_fetch, m_bubble);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_priority();
    test_discard();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
